serial_frame_rx: RTL

//   Serial frame receiver/deserializer; consumes the one-bit stream from the shift-register stage's

---
 rtl/serial_frame_rx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver: start, data, optional parity, stop -> parallel word
module serial_frame_rx #(
  parameter int    DATA_WIDTH      = 8,
  parameter string SHIFT_DIRECTION = "LEFT",
  parameter bit    PARITY_EN       = 1'b1,
  parameter bit    PARITY_ODD      = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_sclr,
  input  logic                  i_enable,
  input  logic                  i_serial_in,
  input  logic                  i_bit_valid,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_valid,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_busy,
  output logic [15:0]           o_frame_cnt
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(DATA_WIDTH - 1);
  localparam bit LP_LEFT = (SHIFT_DIRECTION == "LEFT");

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_RECOVER
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_shadow;
  logic                  r_acc;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_parity_err;
  logic                  r_frame_err;
  logic                  r_busy;
  logic [15:0]           r_frame_cnt;

  logic                  w_qual;
  logic [DATA_WIDTH-1:0] w_shift_next;

  assign w_qual = i_enable & i_bit_valid;

  // LEFT: MSB first, so each new bit enters the LSB; RIGHT: LSB first, new bit enters the MSB.
  assign w_shift_next = LP_LEFT ? {r_shadow[DATA_WIDTH-2:0], i_serial_in}
                                : {i_serial_in, r_shadow[DATA_WIDTH-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shadow     <= '0;
      r_acc        <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_cnt  <= 16'd0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_qual) begin
        case (r_state)
          S_IDLE: begin
            if (!i_serial_in) begin
              r_state <= S_DATA;
              r_cnt   <= '0;
              r_acc   <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          S_DATA: begin
            r_shadow <= w_shift_next;
            r_acc    <= r_acc ^ i_serial_in;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == LP_LAST) begin
              r_state <= PARITY_EN ? S_PARITY : S_STOP;
            end
          end
          S_PARITY: begin
            r_acc   <= r_acc ^ i_serial_in;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_busy <= 1'b0;
            if (i_serial_in) begin
              r_data_out   <= r_shadow;
              r_parity_err <= PARITY_EN ? (r_acc != PARITY_ODD) : 1'b0;
              r_data_valid <= 1'b1;
              r_frame_cnt  <= r_frame_cnt + 16'd1;
              r_state      <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_RECOVER;
            end
          end
          S_RECOVER: begin
            // Wait for the line to return high so a held-low line cannot look like a start bit.
            if (i_serial_in) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = r_busy;
  assign o_frame_cnt  = r_frame_cnt;

endmodule
